ms_dbg_mem_arb: RTL and testbench

// - Arbitrates the single debug memory port between the debug-unit requester (U) and the loader requester (L).
// - Replaces the plain OR-merge of the two masters with a clean, grant-based handover.
// - Tracks in-flight reads so each read-data-valid strobe reaches the master that issued it.
// - Holds off ownership changes until the read pipeline is empty.
// - Bounds how long one master may keep the port while the other is waiting.

---
 rtl/ms_dbg_mem_arb.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ms_dbg_mem_arb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ms_dbg_mem_arb.sv
// ms_dbg_mem_arb - grant-based arbiter for the single debug memory port.
//
// Masters: debug unit U (reads and writes) and loader L (writes only).
// The owner's request/address/data are muxed onto the memory port. Every
// read issued is tracked in a CMemLat-deep {valid, tag} pipeline, so each
// read-data-valid strobe is routed back to the master that issued it.
// Ownership changes only pass through DRAIN, which waits for that pipeline
// to empty. A hold counter bounds how long an owner may keep the port
// while the other master is waiting.
//
// Optional build macro: MS_DBG_MEM_ARB_CONFLICT_CNT_EN
//   When defined, it adds AConflictClr (in) and AConflictCnt[15:0] (out).
//   AConflictCnt is a saturating count of enabled cycles in which the
//   non-owner was requesting. AConflictClr clears it and wins over the
//   increment.

module ms_dbg_mem_arb #(
  parameter int CMemLat  = 2,
  parameter int CMaxHold = 64,
  parameter bit CPrioL   = 1'b0
) (
  input  logic        AClkH,
  input  logic        AResetHN,
  input  logic        AClkHEn,
  input  logic        AReqU,
  input  logic [28:0] AAddrU,
  input  logic [63:0] AMosiU,
  input  logic [1:0]  AWrRdEnU,
  output logic        AGntU,
  output logic        ARdVldU,
  input  logic        AReqL,
  input  logic [28:0] AAddrL,
  input  logic [63:0] AMosiL,
  input  logic        AWrEnL,
  output logic        AGntL,
  output logic        ARdVldL,
  output logic        AMemAccess,
  output logic [28:0] AMemAddr,
  output logic [63:0] AMemMosi,
  output logic [1:0]  AMemWrRdEn,
`ifdef MS_DBG_MEM_ARB_CONFLICT_CNT_EN
  input  logic        AConflictClr,
  output logic [15:0] AConflictCnt,
`endif
  output logic        ABusy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_U = 2'd1;
  localparam logic [1:0] ST_OWN_L = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // The owner is preempted in the cycle where the hold count reaches this value.
  localparam logic [7:0] HOLD_LAST = 8'(CMaxHold - 1);
  localparam logic [7:0] HOLD_SAT  = 8'hFF;

  // Arbiter state
  logic [1:0]         state_q, state_d;
  logic               gnt_u_q, gnt_u_d;
  logic               gnt_l_q, gnt_l_d;
  logic               busy_q, busy_d;
  logic               prev_l_q, prev_l_d;   // 1: L was the last owner before DRAIN
  logic [7:0]         hold_q, hold_d;

  // Read-tracking pipeline; tag 1 marks a read issued by L
  logic [CMemLat-1:0] rd_vld_q, rd_vld_d;
  logic [CMemLat-1:0] rd_tag_q, rd_tag_d;

  // Muxed memory port
  logic               mem_access_s;
  logic [28:0]        mem_addr_s;
  logic [63:0]        mem_mosi_s;
  logic [1:0]         mem_wr_rd_en_s;
  logic               rd_push_s;
  logic               rd_empty_s;

  // Present the owner's access on the memory port; force all fields to zero when nobody is accessing.
  always_comb begin
    mem_access_s   = 1'b0;
    mem_addr_s     = 29'h0;
    mem_mosi_s     = 64'h0;
    mem_wr_rd_en_s = 2'b00;
    if (gnt_u_q && AReqU) begin
      mem_access_s   = 1'b1;
      mem_addr_s     = AAddrU;
      mem_mosi_s     = AMosiU;
      mem_wr_rd_en_s = AWrRdEnU;
    end else if (gnt_l_q && AReqL) begin
      mem_access_s   = 1'b1;
      mem_addr_s     = AAddrL;
      mem_mosi_s     = AMosiL;
      mem_wr_rd_en_s = {AWrEnL, 1'b0};
    end else begin
      mem_access_s   = 1'b0;
      mem_addr_s     = 29'h0;
      mem_mosi_s     = 64'h0;
      mem_wr_rd_en_s = 2'b00;
    end
  end

  // Only a pure read (2'b01) is tracked. A combined 2'b11 strobe counts as a write.
  assign rd_push_s  = mem_access_s & (mem_wr_rd_en_s == 2'b01);
  assign rd_empty_s = ~(|rd_vld_q);

  // Shift the read-tracking pipeline once per enabled cycle, pushing the current read.
  always_comb begin
    rd_vld_d = rd_vld_q;
    rd_tag_d = rd_tag_q;
    if (AClkHEn) begin
      for (int i = CMemLat - 1; i > 0; i--) begin
        rd_vld_d[i] = rd_vld_q[i-1];
        rd_tag_d[i] = rd_tag_q[i-1];
      end
      rd_vld_d[0] = rd_push_s;
      rd_tag_d[0] = rd_push_s & gnt_l_q;
    end else begin
      rd_vld_d = rd_vld_q;
      rd_tag_d = rd_tag_q;
    end
  end

  // Ownership FSM: IDLE picks an owner, OWN_x counts contention, DRAIN waits for reads to land.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    prev_l_d = prev_l_q;
    if (AClkHEn) begin
      case (state_q)
        ST_IDLE: begin
          hold_d = 8'd0;
          if (AReqU && AReqL) begin
            if (CPrioL) begin
              state_d = ST_OWN_L;
            end else begin
              state_d = ST_OWN_U;
            end
          end else if (AReqU) begin
            state_d = ST_OWN_U;
          end else if (AReqL) begin
            state_d = ST_OWN_L;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_OWN_U: begin
          if (!AReqU || ((hold_q == HOLD_LAST) && AReqL)) begin
            state_d  = ST_DRAIN;
            prev_l_d = 1'b0;
          end else if (AReqL && (hold_q != HOLD_SAT)) begin
            hold_d = hold_q + 8'd1;
          end else begin
            hold_d = hold_q;
          end
        end
        ST_OWN_L: begin
          if (!AReqL || ((hold_q == HOLD_LAST) && AReqU)) begin
            state_d  = ST_DRAIN;
            prev_l_d = 1'b1;
          end else if (AReqU && (hold_q != HOLD_SAT)) begin
            hold_d = hold_q + 8'd1;
          end else begin
            hold_d = hold_q;
          end
        end
        ST_DRAIN: begin
          hold_d = 8'd0;
          if (!rd_empty_s) begin
            state_d = ST_DRAIN;
          end else if (prev_l_q) begin
            // The master that did not own the port last gets the first chance.
            if (AReqU) begin
              state_d = ST_OWN_U;
            end else if (AReqL) begin
              state_d = ST_OWN_L;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            if (AReqL) begin
              state_d = ST_OWN_L;
            end else if (AReqU) begin
              state_d = ST_OWN_U;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          hold_d  = 8'd0;
        end
      endcase
    end else begin
      state_d  = state_q;
      hold_d   = hold_q;
      prev_l_d = prev_l_q;
    end
  end

  // Registered grants and busy flag follow the next state, so a grant drops on the same edge that leaves OWN_x.
  always_comb begin
    gnt_u_d = (state_d == ST_OWN_U);
    gnt_l_d = (state_d == ST_OWN_L);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, grant and read-pipeline registers; reset clears everything, including reads still in flight.
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      state_q  <= ST_IDLE;
      gnt_u_q  <= 1'b0;
      gnt_l_q  <= 1'b0;
      busy_q   <= 1'b0;
      prev_l_q <= 1'b0;
      hold_q   <= 8'd0;
      rd_vld_q <= '0;
      rd_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_u_q  <= gnt_u_d;
      gnt_l_q  <= gnt_l_d;
      busy_q   <= busy_d;
      prev_l_q <= prev_l_d;
      hold_q   <= hold_d;
      rd_vld_q <= rd_vld_d;
      rd_tag_q <= rd_tag_d;
    end
  end

`ifdef MS_DBG_MEM_ARB_CONFLICT_CNT_EN
  logic        conflict_s;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  assign conflict_s = (gnt_u_q & AReqL) | (gnt_l_q & AReqU);

  // Saturating count of enabled cycles in which the non-owner was waiting. Clear wins over the increment.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (AClkHEn) begin
      if (AConflictClr) begin
        conflict_cnt_d = 16'd0;
      end else if (conflict_s && (conflict_cnt_q != 16'hFFFF)) begin
        conflict_cnt_d = conflict_cnt_q + 16'd1;
      end else begin
        conflict_cnt_d = conflict_cnt_q;
      end
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // Conflict counter register.
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      conflict_cnt_q <= 16'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign AConflictCnt = conflict_cnt_q;
`endif

  assign AGntU      = gnt_u_q;
  assign AGntL      = gnt_l_q;
  assign ABusy      = busy_q;
  assign ARdVldU    = AClkHEn & rd_vld_q[CMemLat-1] & ~rd_tag_q[CMemLat-1];
  assign ARdVldL    = 1'b0;
  assign AMemAccess = mem_access_s;
  assign AMemAddr   = mem_addr_s;
  assign AMemMosi   = mem_mosi_s;
  assign AMemWrRdEn = mem_wr_rd_en_s;

endmodule

// File: tb/tb_ms_dbg_mem_arb.sv
// Directed testbench for ms_dbg_mem_arb (CMemLat=2, CMaxHold=4, CPrioL=0).
// Inputs change 1 ns after the rising edge. Outputs are sampled 3 ns after it.
module tb_ms_dbg_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        req_u;
  logic [28:0] addr_u;
  logic [63:0] mosi_u;
  logic [1:0]  wrrd_u;
  logic        gnt_u;
  logic        rdvld_u;
  logic        req_l;
  logic [28:0] addr_l;
  logic [63:0] mosi_l;
  logic        wren_l;
  logic        gnt_l;
  logic        rdvld_l;
  logic        access;
  logic [28:0] mem_addr;
  logic [63:0] mem_mosi;
  logic [1:0]  mem_wrrd;
  logic        busy;
`ifdef MS_DBG_MEM_ARB_CONFLICT_CNT_EN
  logic        conflict_clr;
  logic [15:0] conflict_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ms_dbg_mem_arb #(.CMemLat(2), .CMaxHold(4), .CPrioL(1'b0)) dut (
    .AClkH(clk), .AResetHN(rst_n), .AClkHEn(en),
    .AReqU(req_u), .AAddrU(addr_u), .AMosiU(mosi_u), .AWrRdEnU(wrrd_u),
    .AGntU(gnt_u), .ARdVldU(rdvld_u),
    .AReqL(req_l), .AAddrL(addr_l), .AMosiL(mosi_l), .AWrEnL(wren_l),
    .AGntL(gnt_l), .ARdVldL(rdvld_l),
    .AMemAccess(access), .AMemAddr(mem_addr), .AMemMosi(mem_mosi), .AMemWrRdEn(mem_wrrd),
`ifdef MS_DBG_MEM_ARB_CONFLICT_CNT_EN
    .AConflictClr(conflict_clr), .AConflictCnt(conflict_cnt),
`endif
    .ABusy(busy)
  );

  task automatic idle_inputs();
    en = 1'b1; req_u = 1'b0; addr_u = 29'h0; mosi_u = 64'h0; wrrd_u = 2'b00;
    req_l = 1'b0; addr_l = 29'h0; mosi_l = 64'h0; wren_l = 1'b0;
`ifdef MS_DBG_MEM_ARB_CONFLICT_CNT_EN
    conflict_clr = 1'b0;
`endif
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // flags = {gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy}
  task automatic test_reset();
    idle_inputs();
    req_u = 1'b1; wrrd_u = 2'b01; addr_u = 29'h123;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if ({gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000000", {gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy});
    end
    n_checks++;
    if ({mem_addr, mem_wrrd} !== 31'h0 || mem_mosi !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_port got addr=%h wrrd=%b mosi=%h want 0", mem_addr, mem_wrrd, mem_mosi);
    end
`ifdef MS_DBG_MEM_ARB_CONFLICT_CNT_EN
    n_checks++;
    if (conflict_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_conflict got %0d want 0", conflict_cnt);
    end
`endif
    rst_n = 1'b1;
    idle_inputs();
  endtask

  // U alone, four reads at 0x100..0x103; pulses land 2 cycles after each access.
  task automatic test_single_read();
    logic [5:0]  ev;
    logic        ea;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      req_u = (c < 5); wrrd_u = 2'b01; addr_u = 29'h0FF + 29'(c);
      #2;
      ea = (c >= 1 && c <= 4);
      ev = {(c >= 1 && c <= 5), 1'b0, ea, (c >= 3 && c <= 6), 1'b0, (c >= 1 && c <= 7)};
      n_checks++;
      if ({gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy} !== ev) begin
        n_fail++;
        $display("FAIL single_read_flags c=%0d got %b want %b", c, {gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy}, ev);
      end
      n_checks++;
      if (mem_addr !== (ea ? 29'h0FF + 29'(c) : 29'h0) || mem_wrrd !== (ea ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL single_read_port c=%0d got addr=%h wrrd=%b", c, mem_addr, mem_wrrd);
      end
      @(posedge clk); #1;
    end
  endtask

  // Simultaneous requests: U wins, releases after 3 writes, L takes over after DRAIN.
  task automatic test_prio_handover();
    logic [5:0]  ev;
    logic        eu, el;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      req_u = (c <= 3); wrrd_u = 2'b10; addr_u = 29'h200 + 29'(c); mosi_u = 64'h1111_0000_0000_0000 | 64'(c);
      req_l = (c <= 7); wren_l = 1'b1; addr_l = 29'h300 + 29'(c); mosi_l = 64'hA5A5_0000_0000_0000 | 64'(c);
      #2;
      eu = (c >= 1 && c <= 3);
      el = (c == 6 || c == 7);
      ev = {(c >= 1 && c <= 4), (c >= 6 && c <= 8), eu | el, 1'b0, 1'b0, (c >= 1 && c <= 9)};
      n_checks++;
      if ({gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy} !== ev) begin
        n_fail++;
        $display("FAIL handover_flags c=%0d got %b want %b", c, {gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy}, ev);
      end
      n_checks++;
      if (mem_addr !== (eu ? 29'h200 + 29'(c) : el ? 29'h300 + 29'(c) : 29'h0) ||
          mem_mosi !== (eu ? 64'h1111_0000_0000_0000 | 64'(c) : el ? 64'hA5A5_0000_0000_0000 | 64'(c) : 64'h0) ||
          mem_wrrd !== ((eu | el) ? 2'b10 : 2'b00)) begin
        n_fail++;
        $display("FAIL handover_port c=%0d got addr=%h mosi=%h wrrd=%b", c, mem_addr, mem_mosi, mem_wrrd);
      end
      @(posedge clk); #1;
    end
  endtask

  // U reads then releases while L waits: L granted only after the last U pulse; L writes never pulse.
  task automatic test_drain_delay();
    logic [5:0]  ev;
    logic        eu, el;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      req_u = (c <= 2); wrrd_u = 2'b01; addr_u = 29'h400 + 29'(c);
      req_l = (c >= 1 && c <= 7); wren_l = 1'b1; addr_l = 29'h480 + 29'(c);
      #2;
      eu = (c == 1 || c == 2);
      el = (c == 6 || c == 7);
      ev = {(c >= 1 && c <= 3), (c >= 6 && c <= 8), eu | el, (c == 3 || c == 4), 1'b0, (c >= 1 && c <= 9)};
      n_checks++;
      if ({gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy} !== ev) begin
        n_fail++;
        $display("FAIL drain_flags c=%0d got %b want %b", c, {gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy}, ev);
      end
      n_checks++;
      if (mem_wrrd !== (eu ? 2'b01 : el ? 2'b10 : 2'b00) ||
          mem_addr !== (eu ? 29'h400 + 29'(c) : el ? 29'h480 + 29'(c) : 29'h0)) begin
        n_fail++;
        $display("FAIL drain_port c=%0d got addr=%h wrrd=%b", c, mem_addr, mem_wrrd);
      end
      @(posedge clk); #1;
    end
  endtask

  // U holds the port with 2'b11 strobes. L preempts after 4 contended cycles. U is re-granted when L drops.
  task automatic test_preempt();
    logic [5:0]  ev;
    logic        eu, el;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      req_u = (c <= 11); wrrd_u = 2'b11; addr_u = 29'h500 + 29'(c);
      req_l = (c >= 2 && c <= 8); wren_l = 1'b1; addr_l = 29'h580 + 29'(c);
      #2;
      eu = (c >= 1 && c <= 5) || (c == 11);
      el = (c == 7 || c == 8);
      ev = {(c >= 1 && c <= 5) || (c >= 11 && c <= 12), (c >= 7 && c <= 9), eu | el, 1'b0, 1'b0, (c >= 1 && c <= 13)};
      n_checks++;
      if ({gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy} !== ev) begin
        n_fail++;
        $display("FAIL preempt_flags c=%0d got %b want %b", c, {gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy}, ev);
      end
      n_checks++;
      if (mem_wrrd !== (eu ? 2'b11 : el ? 2'b10 : 2'b00) ||
          mem_addr !== (eu ? 29'h500 + 29'(c) : el ? 29'h580 + 29'(c) : 29'h0)) begin
        n_fail++;
        $display("FAIL preempt_port c=%0d got addr=%h wrrd=%b", c, mem_addr, mem_wrrd);
      end
      @(posedge clk); #1;
    end
  endtask

  // Replays the single-read scenario with one disabled cycle before each enabled one.
  task automatic test_clk_en();
    logic [5:0]  ev;
    logic        ea;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      for (int p = 0; p < 2; p++) begin
        en = (p == 1);
        req_u = (c < 5); wrrd_u = 2'b01; addr_u = 29'h0FF + 29'(c);
        #2;
        ea = (c >= 1 && c <= 4);
        ev = {(c >= 1 && c <= 5), 1'b0, ea, (p == 1) && (c >= 3 && c <= 6), 1'b0, (c >= 1 && c <= 7)};
        n_checks++;
        if ({gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy} !== ev) begin
          n_fail++;
          $display("FAIL clk_en_flags c=%0d en=%0d got %b want %b", c, p, {gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy}, ev);
        end
        @(posedge clk); #1;
      end
    end
    en = 1'b1;
  endtask

  // Reset during a read burst: everything zero at once, no stray pulse after release.
  task automatic test_reset_mid();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      req_u = 1'b1; wrrd_u = 2'b01; addr_u = 29'h600 + 29'(c);
      req_l = (c >= 1);
      @(posedge clk); #1;
    end
    #1;
    n_checks++;
    if (rdvld_u !== 1'b1 || gnt_u !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre got rdvld_u=%b gnt_u=%b want 1 1", rdvld_u, gnt_u);
    end
`ifdef MS_DBG_MEM_ARB_CONFLICT_CNT_EN
    n_checks++;
    if (conflict_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL reset_mid_conflict_pre got %0d want 2", conflict_cnt);
    end
`endif
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy} !== 6'b000000 || mem_addr !== 29'h0 || mem_wrrd !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_now got %b addr=%h wrrd=%b want 000000 0 0", {gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy}, mem_addr, mem_wrrd);
    end
`ifdef MS_DBG_MEM_ARB_CONFLICT_CNT_EN
    n_checks++;
    if (conflict_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_conflict got %0d want 0", conflict_cnt);
    end
`endif
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #2;
      n_checks++;
      if ({gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy} !== 6'b000000) begin
        n_fail++;
        $display("FAIL reset_mid_after c=%0d got %b want 000000", c, {gnt_u, gnt_l, access, rdvld_u, rdvld_l, busy});
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_prio_handover();
    test_drain_delay();
    test_preempt();
    test_clk_en();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
